// File: rtl/mem_bw_pkg.sv
// Shared types and helpers for the memory bandwidth override arbiter.
package mem_bw_pkg;

  typedef enum logic [1:0] {
    StWait     = 2'd0,
    StGrant    = 2'd1,
    StCooldown = 2'd2
  } arb_state_e;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int unsigned ch_idx_width(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/mem_bw_rr_select.sv
// Rotating-priority selector: first request at or after ptr_i, wrapping.
module mem_bw_rr_select
  import mem_bw_pkg::*;
#(
  parameter int unsigned Width = 8,
  localparam int unsigned IdxW = ch_idx_width(Width)
) (
  input  logic [Width-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [Width-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  // Walk candidates in priority order starting at the pointer; keep the first hit.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    sum      = '0;
    cand     = '0;
    for (int i = 0; i < int'(Width); i++) begin
      sum = {1'b0, ptr_i} + (IdxW + 1)'(i);
      if (sum >= (IdxW + 1)'(Width)) begin
        sum = sum - (IdxW + 1)'(Width);
      end
      cand = sum[IdxW-1:0];
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_bw_override_arb.sv
// Grants a single AXI channel a bounded burst of priority overrides once the
// memory system has been quiet long enough; round-robin across channels.
module mem_bw_override_arb
  import mem_bw_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned IDLE_W      = 8,
  parameter int unsigned BURST_W     = 4,
  localparam int unsigned CH         = 2 * NUM_MASTERS,
  localparam int unsigned IdxW       = ch_idx_width(CH)
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NUM_MASTERS-1:0] aw_has_outstanding,
  input  logic [NUM_MASTERS-1:0] ar_has_outstanding,
  input  logic [NUM_MASTERS-1:0] aw_can_override,
  input  logic [NUM_MASTERS-1:0] ar_can_override,
  input  logic [NUM_MASTERS-1:0] aw_override_taken,
  input  logic [NUM_MASTERS-1:0] ar_override_taken,
  input  logic                   override_en,
  input  logic [IDLE_W-1:0]      idle_thresh,
  input  logic [BURST_W-1:0]     burst_limit,
  output logic [NUM_MASTERS-1:0] aw_overrides,
  output logic [NUM_MASTERS-1:0] ar_overrides,
  output logic                   grant_valid,
  output logic [IdxW-1:0]        grant_idx
);

  // Channel vectors: aw masters occupy the low half, ar masters the high half.
  logic [CH-1:0] req_vec, taken_vec, sel_onehot, grant_oh_q, ov_vec;
  logic [IdxW-1:0] sel_idx, rr_ptr_q, next_ptr, grant_idx_q;
  logic sel_any, quiet, start_grant, taken_hit, burst_done, end_grant, grant_valid_q;
  logic [IDLE_W-1:0]  quiet_cnt_q;
  logic [BURST_W-1:0] burst_cnt_q, eff_limit;
  logic [BURST_W:0]   burst_inc;
  arb_state_e         state_q;

  assign req_vec   = {ar_can_override, aw_can_override};
  assign taken_vec = {ar_override_taken, aw_override_taken};
  assign quiet     = ~(|aw_has_outstanding) & ~(|ar_has_outstanding);

  mem_bw_rr_select #(
    .Width (CH)
  ) u_rr_select (
    .req_i    (req_vec),
    .ptr_i    (rr_ptr_q),
    .onehot_o (sel_onehot),
    .idx_o    (sel_idx),
    .any_o    (sel_any)
  );

  assign start_grant = override_en & quiet & (quiet_cnt_q >= idle_thresh) & sel_any;

  // A zero limit still allows one token per grant.
  assign eff_limit  = (burst_limit == '0) ? BURST_W'(1) : burst_limit;
  assign taken_hit  = |(taken_vec & grant_oh_q);
  assign burst_inc  = {1'b0, burst_cnt_q} + (BURST_W + 1)'(1);
  assign burst_done = taken_hit & (burst_inc >= {1'b0, eff_limit});
  assign end_grant  = burst_done | ~(|(req_vec & grant_oh_q)) | ~override_en | ~quiet;
  assign next_ptr   = (grant_idx_q == IdxW'(CH - 1)) ? '0 : grant_idx_q + IdxW'(1);

  // Registered grant gated live so it drops the same cycle any condition fails.
  assign ov_vec       = grant_oh_q & req_vec & {CH{quiet & override_en & grant_valid_q}};
  assign aw_overrides = ov_vec[NUM_MASTERS-1:0];
  assign ar_overrides = ov_vec[CH-1:NUM_MASTERS];
  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;

  // Quiet-cycle counter: restarts on any outstanding traffic, saturates.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      quiet_cnt_q <= '0;
    end else if (!quiet) begin
      quiet_cnt_q <= '0;
    end else if (quiet_cnt_q != '1) begin
      quiet_cnt_q <= quiet_cnt_q + IDLE_W'(1);
    end
  end

  // Grant FSM with registered grant state, burst counting and pointer advance.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StWait;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      grant_oh_q    <= '0;
      burst_cnt_q   <= '0;
      rr_ptr_q      <= '0;
    end else begin
      case (state_q)
        StWait: begin
          if (start_grant) begin
            state_q       <= StGrant;
            grant_valid_q <= 1'b1;
            grant_idx_q   <= sel_idx;
            grant_oh_q    <= sel_onehot;
            burst_cnt_q   <= '0;
          end
        end
        StGrant: begin
          if (end_grant) begin
            state_q       <= StCooldown;
            grant_valid_q <= 1'b0;
            grant_oh_q    <= '0;
            burst_cnt_q   <= '0;
            rr_ptr_q      <= next_ptr;
          end else if (taken_hit) begin
            burst_cnt_q <= burst_inc[BURST_W-1:0];
          end
        end
        StCooldown: begin
          state_q <= StWait;
        end
        default: begin
          state_q       <= StWait;
          grant_valid_q <= 1'b0;
          grant_oh_q    <= '0;
        end
      endcase
    end
  end

endmodule
